// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC serial-link initiator.
// Holds the FSM encoding, frame geometry and the address-bit lookup.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int FRAME_BITS     = 16;
  localparam int ADDR_W         = 3;
  localparam int ADDR_FIRST_BIT = 2;
  localparam int BIT_W          = $clog2(FRAME_BITS);

  // Value of din for bit slot bit_idx: address MSB first, zero elsewhere.
  function automatic logic addr_bit(input logic [BIT_W-1:0] bit_idx,
                                    input logic [ADDR_W-1:0] addr);
    logic r;
    r = 1'b0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (int'(bit_idx) == ADDR_FIRST_BIT + i) r = addr[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_spi_if.sv
// Control/status and serial-pin bundle between the ADC initiator and its user.
interface adc_spi_if #(
  parameter int NUM_CH = 8
);
  import adc_spi_pkg::*;

  logic                enable;
  logic [NUM_CH-1:0]   chan_mask;
  logic                cs_adc;
  logic                sclk_adc;
  logic                din_adc;
  logic                busy;
  logic                frame_done;
  logic [ADDR_W-1:0]   frame_chan;

  modport master (
    input  enable, chan_mask,
    output cs_adc, sclk_adc, din_adc, busy, frame_done, frame_chan
  );

  modport slave (
    output enable, chan_mask,
    input  cs_adc, sclk_adc, din_adc, busy, frame_done, frame_chan
  );

endinterface

// File: rtl/adc_chan_seq.sv
// Round-robin channel picker: on load, registers the next enabled channel
// after prev_addr (or the lowest enabled channel when starting from idle).
module adc_chan_seq
  import adc_spi_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              from_idle,
  input  logic [NUM_CH-1:0] mask,
  input  logic [ADDR_W-1:0] prev_addr,
  output logic [ADDR_W-1:0] cur_addr
);

  logic [ADDR_W-1:0] start;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] pick;
  logic              found;

  always_comb begin
    start = from_idle ? '0 : prev_addr + 1'b1;
    pick  = cur_addr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ADDR_W'((int'(start) + i) % NUM_CH);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       cur_addr <= '0;
    else if (load) cur_addr <= pick;
  end

endmodule

// File: rtl/adc_spi_master.sv
// ADC serial-link initiator: back-to-back 16-clock frames carrying a 3-bit
// channel address, with round-robin sequencing and per-frame channel report.
module adc_spi_master
  import adc_spi_pkg::*;
#(
  parameter int SCLK_DIV = 4,
  parameter int CS_GAP   = 8,
  parameter int NUM_CH   = 8
) (
  input  logic      clk,
  input  logic      rst,
  adc_spi_if.master bus
);

  localparam int CNT_MAX = (SCLK_DIV > CS_GAP) ? SCLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              phase, phase_nxt;   // 0: SCLK low half, 1: high half
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [ADDR_W-1:0] prev_addr, cur_addr;
  logic              load, from_idle, frame_end, run_ok, active_nxt;

  adc_chan_seq #(.NUM_CH(NUM_CH)) u_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .from_idle (from_idle),
    .mask      (bus.chan_mask),
    .prev_addr (prev_addr),
    .cur_addr  (cur_addr)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    load      = 1'b0;
    from_idle = 1'b0;
    frame_end = 1'b0;
    run_ok    = bus.enable && (|bus.chan_mask);
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (run_ok) begin
          state_nxt = ST_SETUP;
          load      = 1'b1;
          from_idle = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt == HALF_LAST) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
          phase_nxt = 1'b0;
          bit_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (!phase) begin
            phase_nxt = 1'b1;
          end else if (bit_cnt == BIT_LAST) begin
            state_nxt = ST_GAP;
            frame_end = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            bit_nxt   = bit_cnt + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (run_ok) begin
            state_nxt = ST_SETUP;
            load      = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    active_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_SHIFT);
  end

  // Pin outputs are registered from next-state values so they change
  // together with the state and never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      phase          <= 1'b0;
      bit_cnt        <= '0;
      prev_addr      <= '0;
      bus.cs_adc     <= 1'b1;
      bus.sclk_adc   <= 1'b1;
      bus.din_adc    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_chan <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      phase          <= phase_nxt;
      bit_cnt        <= bit_nxt;
      bus.cs_adc     <= !active_nxt;
      bus.busy       <= active_nxt;
      bus.sclk_adc   <= !((state_nxt == ST_SHIFT) && !phase_nxt);
      bus.din_adc    <= (state_nxt == ST_SHIFT) ? addr_bit(bit_nxt, cur_addr) : 1'b0;
      bus.frame_done <= frame_end;
      if (frame_end) begin
        bus.frame_chan <= prev_addr;
        prev_addr      <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: table of channel masks with expected address
// sequences, hand-written corner sequences, and a pin-level frame monitor.
module tb_adc_spi_master;
  import adc_spi_pkg::*;

  localparam int SCLK_DIV = 4;
  localparam int CS_GAP   = 8;
  localparam int NUM_CH   = 8;
  localparam int LOW_LEN  = SCLK_DIV * 33;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_spi_if #(.NUM_CH(NUM_CH)) bus ();

  adc_spi_master #(.SCLK_DIV(SCLK_DIV), .CS_GAP(CS_GAP), .NUM_CH(NUM_CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] addr;
    logic [2:0] chan;
    bit         b2b;
    bit         abort;
  } exp_t;

  typedef struct {
    logic [7:0] mask;
    logic [2:0] a [4];
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] addr, input logic [2:0] chan,
                          input bit b2b, input bit abort);
    exp_t e;
    e.addr = addr; e.chan = chan; e.b2b = b2b; e.abort = abort;
    sb.push_back(e);
  endtask

  // Frame monitor, sampled on the falling system clock edge.
  bit          mon_en = 1'b0;
  bit          prev_cs = 1'b1, prev_sclk = 1'b1;
  bit          unstable, idle_err = 1'b0;
  int          done_cnt = 0, frame_id = 0;
  int          mon_falls = 0, rises = 0, low_cnt = 0, high_cnt = 0;
  logic [15:0] word;
  logic        hold_din;

  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (bus.busy !== !bus.cs_adc) idle_err = 1'b1;
      if (bus.cs_adc === 1'b1 && bus.sclk_adc !== 1'b1) idle_err = 1'b1;
      if (bus.frame_done === 1'b1) begin
        done_cnt++;
        if (!(!prev_cs && bus.cs_adc === 1'b1)) check("stray_frame_done", 1, 0);
      end
      if (prev_cs && bus.cs_adc === 1'b0) begin
        if (sb.size() == 0) check("unexpected_frame_start", 1, 0);
        else if (sb[0].b2b) check("cs_gap_len", high_cnt, CS_GAP);
        frame_id++;
        low_cnt = 0; mon_falls = 0; rises = 0; word = '0; unstable = 1'b0;
      end
      if (!prev_cs && bus.cs_adc === 1'b1) begin
        high_cnt = 0;
        if (sb.size() == 0) begin
          check("unexpected_frame_end", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.abort) begin
            check("abort_no_frame_done", bus.frame_done, 0);
          end else begin
            check("frame_done_on_cs_rise", bus.frame_done, 1);
            check("cs_low_len", low_cnt, LOW_LEN);
            check("sclk_falls", mon_falls, 16);
            check("sclk_rises", rises, 16);
            check("din_word", word, {2'b00, e.addr, 11'b0});
            check("frame_chan", bus.frame_chan, e.chan);
            check("din_stable_sclk_high", unstable, 0);
          end
        end
      end
      if (bus.cs_adc === 1'b0) begin
        low_cnt++;
        if (prev_sclk && bus.sclk_adc === 1'b0) begin
          mon_falls++;
        end else if (!prev_sclk && bus.sclk_adc === 1'b1) begin
          word     = {word[14:0], bus.din_adc};
          hold_din = bus.din_adc;
          rises++;
        end else if (bus.sclk_adc === 1'b1 && rises > 0 && bus.din_adc !== hold_din) begin
          unstable = 1'b1;
        end
      end else begin
        high_cnt++;
      end
    end
    prev_cs   = (bus.cs_adc !== 1'b0);
    prev_sclk = (bus.sclk_adc !== 1'b0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string name);
    int target, budget;
    target = done_cnt + n;
    budget = n * (LOW_LEN + CS_GAP) + 200;
    while (done_cnt < target && budget > 0) begin
      tick();
      budget--;
    end
    check({name, "_frames_timeout"}, done_cnt >= target, 1);
  endtask

  task automatic wait_bit(input int fid, input int falls, input string name);
    int budget;
    budget = 2 * (LOW_LEN + CS_GAP);
    while (!(frame_id > fid && mon_falls >= falls) && budget > 0) begin
      tick();
      budget--;
    end
    check({name, "_bit_timeout"}, budget > 0, 1);
  endtask

  task automatic set_vec(input int i, input logic [7:0] m, input logic [2:0] a0,
                         input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] a3);
    vecs[i].mask = m;
    vecs[i].a[0] = a0; vecs[i].a[1] = a1; vecs[i].a[2] = a2; vecs[i].a[3] = a3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, fid, bad;
    set_vec(0, 8'h01,        3'd0, 3'd0, 3'd0, 3'd0);
    set_vec(1, 8'b1010_0100, 3'd2, 3'd5, 3'd7, 3'd2);
    set_vec(2, 8'h80,        3'd7, 3'd7, 3'd7, 3'd7);
    set_vec(3, 8'h81,        3'd0, 3'd7, 3'd0, 3'd7);
    set_vec(4, 8'hFF,        3'd0, 3'd1, 3'd2, 3'd3);
    set_vec(5, 8'h24,        3'd2, 3'd5, 3'd2, 3'd5);

    rst = 1'b1;
    bus.enable = 1'b0;
    bus.chan_mask = '0;
    tick(3);
    check("rst_cs_adc", bus.cs_adc, 1);
    check("rst_sclk_adc", bus.sclk_adc, 1);
    check("rst_din_adc", bus.din_adc, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_frame_chan", bus.frame_chan, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // T1: single channel 0, chip select falls one cycle after enable
    bus.chan_mask = 8'h01;
    bus.enable = 1'b1;
    push_exp(3'd0, 3'd0, 1'b0, 1'b0);
    check("t1_cs_before_edge", bus.cs_adc, 1);
    tick(1);
    check("t1_cs_fell", bus.cs_adc, 0);
    check("t1_busy", bus.busy, 1);
    wait_frames(1, "t1");
    bus.enable = 1'b0;
    tick(30);
    check("t1_idle_cs", bus.cs_adc, 1);

    // Table: each mask from reset, four back-to-back frames
    for (int v = 0; v < 6; v++) begin
      do_reset();
      bus.chan_mask = vecs[v].mask;
      bus.enable = 1'b1;
      for (int i = 0; i < 4; i++)
        push_exp(vecs[v].a[i], (i == 0) ? 3'd0 : vecs[v].a[i-1], i > 0, 1'b0);
      wait_frames(4, "vec");
      bus.enable = 1'b0;
      tick(30);
      check("vec_sb_empty", sb.size(), 0);
      check("vec_idle_cs", bus.cs_adc, 1);
    end

    // T3: empty mask never starts a frame
    do_reset();
    bus.chan_mask = 8'h00;
    bus.enable = 1'b1;
    d0 = done_cnt;
    bad = 0;
    repeat (500) begin
      @(negedge clk); #1;
      if (bus.cs_adc !== 1'b1 || bus.sclk_adc !== 1'b1 || bus.busy !== 1'b0) bad = 1;
    end
    check("t3_idle_pins", bad, 0);
    check("t3_no_frame_done", done_cnt - d0, 0);
    bus.enable = 1'b0;

    // T4: enable drops at bit 8, frame completes, then idle
    do_reset();
    bus.chan_mask = 8'h08;
    fid = frame_id;
    bus.enable = 1'b1;
    push_exp(3'd3, 3'd0, 1'b0, 1'b0);
    wait_bit(fid, 9, "t4");
    bus.enable = 1'b0;
    d0 = done_cnt;
    wait_frames(1, "t4");
    tick(300);
    check("t4_one_frame_done", done_cnt - d0, 1);
    check("t4_idle_cs", bus.cs_adc, 1);
    check("t4_sb_empty", sb.size(), 0);

    // T5: reset during bit 3 low half aborts the frame
    do_reset();
    bus.chan_mask = 8'h02;
    fid = frame_id;
    bus.enable = 1'b1;
    push_exp(3'd1, 3'd0, 1'b0, 1'b1);
    wait_bit(fid, 4, "t5");
    check("t5_sclk_low_at_rst", bus.sclk_adc, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    push_exp(3'd1, 3'd0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("t5_cs_after_rst", bus.cs_adc, 1);
    check("t5_sclk_after_rst", bus.sclk_adc, 1);
    check("t5_din_after_rst", bus.din_adc, 0);
    check("t5_busy_after_rst", bus.busy, 0);
    check("t5_done_after_rst", bus.frame_done, 0);
    wait_frames(1, "t5");
    bus.enable = 1'b0;
    tick(30);
    check("t5_sb_empty", sb.size(), 0);

    // T6: mask change at bit 10 applies from the next frame
    do_reset();
    bus.chan_mask = 8'h0F;
    fid = frame_id;
    bus.enable = 1'b1;
    push_exp(3'd0, 3'd0, 1'b0, 1'b0);
    wait_bit(fid, 11, "t6");
    bus.chan_mask = 8'hF0;
    push_exp(3'd4, 3'd0, 1'b1, 1'b0);
    push_exp(3'd5, 3'd4, 1'b1, 1'b0);
    wait_frames(3, "t6");
    bus.enable = 1'b0;
    tick(30);
    check("t6_sb_empty", sb.size(), 0);

    check("busy_and_idle_sclk_consistent", idle_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
